// File: rtl/fpio_fifo_out_client_core.sv
// Read client for the output side of an fpio FIFO: one request -> one data_en strobe -> one captured response word.
// Latency: response valid 2 cycles after request accept; +1 per cycle of avail==0 or of data_ack delay.
// Backpressure: a single read in flight; req_ready stays low until the held response is taken via rsp_ready.
// Optional feature: define FPIO_FIFO_OUT_CLIENT_COUNT_EN to add the read_count completed-read counter port.
module fpio_fifo_out_client_core #(
  parameter int FIFO_BITS   = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic [FIFO_BITS:0]    avail,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  data_en,
  input  logic                  data_ack
`ifdef FPIO_FIFO_OUT_CLIENT_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] read_count
`endif
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t state;
  state_t next_state;
  logic   pending;
  logic   accept;
  logic   issue;
  logic   capture;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode: leave IDLE only when a strobe is issued, return on the ack
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (pending && (avail != '0)) next_state = WAIT_ACK;
      WAIT_ACK: if (data_ack) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode: handshake and control strobes derived from registers and inputs
  always_comb begin
    req_ready = ready && (state == IDLE) && !pending && !rsp_valid;
    accept    = req_valid && req_ready;
    issue     = (state == IDLE) && pending && (avail != '0);
    capture   = (state == WAIT_ACK) && data_ack;
  end

  // Ready flag: rises on the first edge out of reset
  always_ff @(posedge clk) begin
    if (rst) ready <= 1'b0;
    else     ready <= 1'b1;
  end

  // Pending request: set on accept, consumed when the strobe goes out
  always_ff @(posedge clk) begin
    if (rst)         pending <= 1'b0;
    else if (issue)  pending <= 1'b0;
    else if (accept) pending <= 1'b1;
  end

  // Read strobe: high for exactly the one cycle after issue
  always_ff @(posedge clk) begin
    if (rst) data_en <= 1'b0;
    else     data_en <= issue;
  end

  // Response holding register: capture on ack, hold until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef FPIO_FIFO_OUT_CLIENT_COUNT_EN
  // Completed-read counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (rst)          read_count <= '0;
    else if (capture) read_count <= read_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fpio_fifo_out_client_core.sv
// Directed bench for fpio_fifo_out_client_core.
// Expected response words are queued when the FIFO side is driven and compared when the response is taken.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fpio_fifo_out_client_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        req_valid;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [16:0] avail;
  logic [7:0]  data;
  logic        data_en;
  logic        data_ack;
`ifdef FPIO_FIFO_OUT_CLIENT_COUNT_EN
  logic [31:0] read_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fpio_fifo_out_client_core #(
    .FIFO_BITS(16),
    .DATA_WIDTH(8),
    .COUNT_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ready(ready),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .avail(avail),
    .data(data),
    .data_en(data_en),
    .data_ack(data_ack)
`ifdef FPIO_FIFO_OUT_CLIENT_COUNT_EN
    ,
    .read_count(read_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request until it is accepted on an edge (bounded)
  task automatic do_req(input string tag);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        tick();
        acc = 1'b1;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    chk({tag, "_accept"}, {31'b0, acc}, 32'd1);
  endtask

  // Wait for a response (bounded), compare with the scoreboard, then consume it
  task automatic get_rsp(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    chk({tag, "_rsp_data"}, {24'b0, rsp_data}, {24'b0, e});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_clr"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  // Full read: request, strobe next cycle, ack in the strobe cycle, take the response
  task automatic do_read(input string tag, input logic [7:0] d);
    do_req(tag);
    tick();
    chk({tag, "_data_en"}, {31'b0, data_en}, 32'd1);
    data = d;
    data_ack = 1'b1;
    exp_q.push_back(d);
    tick();
    data_ack = 1'b0;
    get_rsp(tag);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    avail = '0;
    data = '0;
    data_ack = 1'b0;
    tick();
    req_valid = 1'b1;
    tick();
    // Reset state, request ignored while in reset
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
    chk("rst_data_en", {31'b0, data_en}, 32'd0);
`ifdef FPIO_FIFO_OUT_CLIENT_COUNT_EN
    chk("rst_count", read_count, 32'd0);
`endif
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rel_ready", {31'b0, ready}, 32'd1);
    chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

    // data_ack ignored while idle
    data_ack = 1'b1;
    data = 8'hEE;
    tick();
    data_ack = 1'b0;
    chk("idle_ack_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Basic read, ack in strobe cycle, 2-cycle latency
    avail = 17'd3;
    do_req("t1");
    chk("t1_e0_data_en", {31'b0, data_en}, 32'd0);
    chk("t1_e0_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("t1_e1_data_en", {31'b0, data_en}, 32'd1);
    data = 8'h5A;
    data_ack = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    data_ack = 1'b0;
    chk("t1_e2_data_en", {31'b0, data_en}, 32'd0);
    chk("t1_e2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    get_rsp("t1");

    // FIFO empty for 5 cycles after request
    avail = '0;
    do_req("t2");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_empty_data_en", {31'b0, data_en}, 32'd0);
    end
    avail = 17'd1;
    tick();
    chk("t2_data_en", {31'b0, data_en}, 32'd1);
    data = 8'h11;
    data_ack = 1'b1;
    exp_q.push_back(8'h11);
    tick();
    data_ack = 1'b0;
    chk("t2_data_en_drop", {31'b0, data_en}, 32'd0);
    get_rsp("t2");

    // Ack delayed 4 cycles after the strobe
    avail = 17'd2;
    do_req("t3");
    tick();
    chk("t3_data_en", {31'b0, data_en}, 32'd1);
    data = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_wait_data_en", {31'b0, data_en}, 32'd0);
      chk("t3_wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    data_ack = 1'b1;
    exp_q.push_back(8'hC3);
    tick();
    data_ack = 1'b0;
    data = 8'h00;
    chk("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    get_rsp("t3");

    // Consumer backpressure for 3 cycles
    do_req("t4");
    tick();
    data = 8'h7E;
    data_ack = 1'b1;
    exp_q.push_back(8'h7E);
    tick();
    data_ack = 1'b0;
    data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("t4_hold_data", {24'b0, rsp_data}, 32'h7E);
      chk("t4_hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    get_rsp("t4");
    chk("t4_req_ready_after", {31'b0, req_ready}, 32'd1);
    do_read("t4b", 8'h33);

    // Reset while waiting for the ack
    do_req("t5");
    tick();
    chk("t5_data_en", {31'b0, data_en}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_rst_data_en", {31'b0, data_en}, 32'd0);
    chk("t5_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t5_rst_ready", {31'b0, ready}, 32'd0);
`ifdef FPIO_FIFO_OUT_CLIENT_COUNT_EN
    chk("t5_rst_count", read_count, 32'd0);
`endif
    rst = 1'b0;
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    chk("t5_ready", {31'b0, ready}, 32'd1);
    // The discarded request must not produce a strobe or a response
    tick();
    chk("t5_no_strobe", {31'b0, data_en}, 32'd0);
    chk("t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("t5_req_ready", {31'b0, req_ready}, 32'd1);

    do_read("t6a", 8'hA1);
    do_read("t6b", 8'hB2);
`ifdef FPIO_FIFO_OUT_CLIENT_COUNT_EN
    chk("t6_count", read_count, 32'd2);
`endif
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
